gravador_jogadas: RTL and testbench

- Capture side of the LED-pattern game: the pattern memory drives one-hot 4-bit LED codes; this block takes the player's 4 buttons and turns them into one-hot 4-bit codes in the same format.
- Synchronizes, debounces and validates presses, then writes each accepted code into an internal 16x4 RAM at an incrementing address.
- The comparator reads the RAM back through a synchronous port with 1-cycle latency, addressed like the pattern memory.

---
 rtl/gravador_jogadas.sv | 111 +++++++++++
 tb/tb_gravador_jogadas.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gravador_jogadas.sv
// Player-side capture for the LED-pattern game: synchronizes, debounces and validates
// button presses, storing each accepted one-hot code in a 16x4 RAM with a registered read port.
module gravador_jogadas #(
   parameter int DEBOUNCE = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       limpa,
   input  logic       habilita,
   input  logic [3:0] botoes,
   input  logic [3:0] limite,
   input  logic [3:0] rd_address,
   output logic [3:0] rd_data,
   output logic [3:0] jogada,
   output logic       jogada_valida,
   output logic       erro_codigo,
   output logic [4:0] contagem,
   output logic       cheio
);

   typedef enum logic [2:0] {LIVRE, ARMADO, ESTAVEL, GRAVA, SOLTA} estado_t;

   localparam logic [7:0] DEB = 8'(DEBOUNCE);

   estado_t    estado;
   logic [3:0] sync1;
   logic [3:0] s;
   logic [3:0] cand;
   logic [7:0] cnt;
   logic [3:0] mem [16];
   logic       cand_one_hot;
   logic       escreve;

   assign cand_one_hot = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
   // A clear on the same edge as GRAVA suppresses the write along with the pulse.
   assign escreve = (estado == GRAVA) && !limpa && cand_one_hot && !cheio
                    && (contagem != 5'd16);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1         <= 4'd0;
         s             <= 4'd0;
         estado        <= LIVRE;
         cand          <= 4'd0;
         cnt           <= 8'd0;
         contagem      <= 5'd0;
         jogada        <= 4'd0;
         jogada_valida <= 1'b0;
         erro_codigo   <= 1'b0;
         cheio         <= 1'b0;
         rd_data       <= 4'd0;
      end else begin
         sync1         <= botoes;
         s             <= sync1;
         rd_data       <= mem[rd_address];
         jogada_valida <= 1'b0;
         erro_codigo   <= 1'b0;
         cheio         <= contagem > {1'b0, limite};

         if (limpa) begin
            contagem <= 5'd0;
            cheio    <= 1'b0;
            estado   <= SOLTA;
         end else begin
            case (estado)
               LIVRE, SOLTA: begin
                  if (s == 4'd0) estado <= ARMADO;
               end
               ARMADO: begin
                  if (habilita && s != 4'd0) begin
                     cand   <= s;
                     cnt    <= 8'd1;
                     estado <= ESTAVEL;
                  end
               end
               ESTAVEL: begin
                  if (!habilita) begin
                     estado <= SOLTA;
                  end else if (s == 4'd0) begin
                     estado <= ARMADO;
                  end else if (s != cand) begin
                     cand <= s;
                     cnt  <= 8'd1;
                  end else if (cnt == DEB) begin
                     estado <= GRAVA;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               GRAVA: begin
                  if (escreve) begin
                     jogada        <= cand;
                     jogada_valida <= 1'b1;
                     contagem      <= contagem + 5'd1;
                  end else if (!cand_one_hot) begin
                     erro_codigo <= 1'b1;
                  end
                  estado <= SOLTA;
               end
               default: estado <= LIVRE;
            endcase
         end
      end
   end

   // RAM contents survive reset; read-first falls out of the nonblocking read above.
   always_ff @(posedge clock) begin
      if (escreve) mem[contagem[3:0]] <= cand;
   end

endmodule

// File: tb/tb_gravador_jogadas.sv
// Directed self-checking bench for gravador_jogadas with DEBOUNCE=4.
module tb_gravador_jogadas;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       limpa;
   logic       habilita;
   logic [3:0] botoes;
   logic [3:0] limite;
   logic [3:0] rd_address;
   logic [3:0] rd_data;
   logic [3:0] jogada;
   logic       jogada_valida;
   logic       erro_codigo;
   logic [4:0] contagem;
   logic       cheio;

   int checks = 0;
   int failures = 0;

   gravador_jogadas #(.DEBOUNCE(4)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .limpa(limpa),
      .habilita(habilita),
      .botoes(botoes),
      .limite(limite),
      .rd_address(rd_address),
      .rd_data(rd_data),
      .jogada(jogada),
      .jogada_valida(jogada_valida),
      .erro_codigo(erro_codigo),
      .contagem(contagem),
      .cheio(cheio)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Hold a code for a number of edges, release it, and count pulses seen throughout.
   task automatic applyStimulus(input logic [3:0] code, input int hold, output int pulses, output int errs);
      pulses = 0;
      errs = 0;
      botoes = code;
      for (int i = 0; i < hold + 6; i++) begin
         if (i == hold) botoes = 4'd0;
         tick();
         if (jogada_valida) pulses++;
         if (erro_codigo) errs++;
      end
   endtask

   task automatic clearPointer();
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      repeat (4) tick();
   endtask

   task automatic readMem(input logic [3:0] addr, input logic [3:0] expected, input string tag);
      rd_address = addr;
      tick();
      checkOutput(tag, {4'd0, rd_data}, {4'd0, expected});
   endtask

   initial begin
      int pulses;
      int errs;
      int first;

      reset_n = 1'b0;
      limpa = 1'b0;
      habilita = 1'b1;
      botoes = 4'd0;
      limite = 4'd15;
      rd_address = 4'd0;
      #2;
      checkOutput("reset_contagem", {3'd0, contagem}, 8'd0);
      checkOutput("reset_jogada", {4'd0, jogada}, 8'd0);
      checkOutput("reset_pulses", {6'd0, jogada_valida, erro_codigo}, 8'd0);
      checkOutput("reset_cheio_rd", {3'd0, cheio, rd_data}, 8'd0);
      #10 reset_n = 1'b1;
      repeat (3) tick();

      // Single clean press: pulse must appear exactly after edge N+7.
      botoes = 4'b0001;
      pulses = 0;
      first = -1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (jogada_valida) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      checkOutput("latency_edge", 8'(first), 8'd7);
      checkOutput("single_pulse", 8'(pulses), 8'd1);
      checkOutput("jogada_0001", {4'd0, jogada}, 8'b0001);
      checkOutput("contagem_1", {3'd0, contagem}, 8'd1);
      botoes = 4'd0;
      repeat (6) tick();
      readMem(4'd0, 4'b0001, "mem0_0001");

      // Bouncing button then steady hold.
      clearPointer();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         botoes = 4'b0010;
         repeat (2) begin tick(); if (jogada_valida) pulses++; end
         botoes = 4'b0000;
         repeat (2) begin tick(); if (jogada_valida) pulses++; end
      end
      checkOutput("bounce_no_pulse", 8'(pulses), 8'd0);
      applyStimulus(4'b0010, 12, pulses, errs);
      checkOutput("bounce_one_pulse", 8'(pulses), 8'd1);
      checkOutput("bounce_contagem", {3'd0, contagem}, 8'd1);
      readMem(4'd0, 4'b0010, "bounce_mem0");

      // Non-one-hot press is rejected.
      applyStimulus(4'b0101, 12, pulses, errs);
      checkOutput("bad_code_err", 8'(errs), 8'd1);
      checkOutput("bad_code_valid", 8'(pulses), 8'd0);
      checkOutput("bad_code_contagem", {3'd0, contagem}, 8'd1);
      checkOutput("bad_code_jogada", {4'd0, jogada}, 8'b0010);
      readMem(4'd0, 4'b0010, "bad_code_mem0");

      // Pre-fill slots 0..3, then fill with limite=2 and check the overflow press is dropped.
      clearPointer();
      for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 10, pulses, errs);
      checkOutput("prefill_contagem", {3'd0, contagem}, 8'd4);
      clearPointer();
      limite = 4'd2;
      applyStimulus(4'b0001, 10, pulses, errs);
      applyStimulus(4'b0010, 10, pulses, errs);
      checkOutput("fill_cheio_early", {7'd0, cheio}, 8'd0);
      applyStimulus(4'b0100, 10, pulses, errs);
      checkOutput("fill_third_pulse", 8'(pulses), 8'd1);
      checkOutput("fill_cheio", {7'd0, cheio}, 8'd1);
      applyStimulus(4'b1000, 10, pulses, errs);
      checkOutput("full_ignored", 8'(pulses + errs), 8'd0);
      checkOutput("full_contagem", {3'd0, contagem}, 8'd3);
      checkOutput("full_jogada", {4'd0, jogada}, 8'b0100);
      readMem(4'd0, 4'b0001, "fill_mem0");
      readMem(4'd1, 4'b0010, "fill_mem1");
      readMem(4'd2, 4'b0100, "fill_mem2");
      readMem(4'd3, 4'b0100, "fill_mem3_kept");

      // limpa on the GRAVA edge suppresses write and pulse.
      limite = 4'd15;
      clearPointer();
      applyStimulus(4'b0010, 10, pulses, errs);
      rd_address = 4'd0;
      botoes = 4'b0001;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin tick(); if (jogada_valida) pulses++; end
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      if (jogada_valida) pulses++;
      checkOutput("limpa_no_pulse", 8'(pulses), 8'd0);
      checkOutput("limpa_contagem", {3'd0, contagem}, 8'd0);
      checkOutput("limpa_jogada_kept", {4'd0, jogada}, 8'b0010);
      tick();
      checkOutput("limpa_no_write", {4'd0, rd_data}, 8'b0010);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin tick(); if (jogada_valida) pulses++; end
      checkOutput("limpa_held_ignored", 8'(pulses), 8'd0);
      botoes = 4'd0;
      repeat (6) tick();
      applyStimulus(4'b0100, 10, pulses, errs);
      checkOutput("after_limpa_pulse", 8'(pulses), 8'd1);
      readMem(4'd0, 4'b0100, "after_limpa_mem0");

      // Asynchronous reset mid-debounce.
      botoes = 4'b1000;
      repeat (4) tick();
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_contagem", {3'd0, contagem}, 8'd0);
      checkOutput("async_jogada_rd", {jogada, rd_data}, 8'd0);
      checkOutput("async_flags", {5'd0, cheio, jogada_valida, erro_codigo}, 8'd0);
      #3 reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (jogada_valida) pulses++; end
      checkOutput("rearm_one_pulse", 8'(pulses), 8'd1);
      checkOutput("rearm_contagem", {3'd0, contagem}, 8'd1);
      checkOutput("rearm_jogada", {4'd0, jogada}, 8'b1000);
      botoes = 4'd0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
